// File: rtl/ctrl_seq_fsm.sv
// Per-request crypto sequencer: key read, text read, accelerator exec, write-back, completion.
// Optional ack-timeout retry is enabled by defining ACK_TIMEOUT_EN.
module ctrl_seq_fsm #(
    parameter int                     ADDR_W        = 10,
    parameter int                     CPU_OPCODE_W  = 2,
    parameter int                     OPCODE_W      = 2,
    parameter int                     WIDTH_ENC_W   = 3,
    parameter int                     SRC_ID_W      = 4,
    parameter int                     OUR_SRC_ID    = 0,
    parameter logic [WIDTH_ENC_W-1:0] KEY_WIDTH_ENC = WIDTH_ENC_W'(4),
    parameter int                     TIMEOUT_CYC   = 64,
    parameter int                     MAX_RETRY     = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_req_valid,
    output logic                    cpu_req_ready,
    input  logic [CPU_OPCODE_W-1:0] cpu_req_opcode,
    input  logic [ADDR_W-1:0]       cpu_req_key_addr,
    input  logic [ADDR_W-1:0]       cpu_req_text_addr,
    input  logic [WIDTH_ENC_W-1:0]  cpu_req_text_width,
    input  logic                    mem_ready,
    input  logic                    arb_won,
    input  logic                    ack,
    input  logic                    ack_tag,
    output logic                    req_valid,
    output logic [ADDR_W-1:0]       req_addr,
    output logic [WIDTH_ENC_W-1:0]  req_width,
    output logic [OPCODE_W-1:0]     req_opcode,
    output logic                    req_accel_op,
    output logic [SRC_ID_W-1:0]     req_source_id,
    output logic                    req_tag,
    output logic                    req_is_mem,
    output logic                    cmpl_valid,
    output logic [ADDR_W-1:0]       cmpl_addr,
    output logic [SRC_ID_W-1:0]     cmpl_source_id,
    output logic                    cmpl_err,
    input  logic                    serializer_arb_won
);
    // state      | meaning
    // IDLE       | waiting for a CPU request
    // RD_KEY     | key read from memory (AES only)
    // RD_TEXT    | text read from memory
    // EXEC       | accelerator execute command
    // WB         | write-back address (tag 0) and data (tag 1)
    // COMPLETE   | completion offered to the serializer
    typedef enum logic [2:0] {S_IDLE, S_RD_KEY, S_RD_TEXT, S_EXEC, S_WB, S_COMPLETE} state_t;

    localparam logic [CPU_OPCODE_W-1:0] OP_AES_DEC  = CPU_OPCODE_W'(1);
    localparam logic [CPU_OPCODE_W-1:0] OP_SHA      = CPU_OPCODE_W'(2);
    localparam logic [CPU_OPCODE_W-1:0] OP_RESERVED = CPU_OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] NOC_MEM_READ   = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] NOC_WRITE_ADDR = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] NOC_WRITE_DATA = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] NOC_EXEC       = OPCODE_W'(3);

    state_t                  state, state_next;
    logic [CPU_OPCODE_W-1:0] op_q;
    logic [ADDR_W-1:0]       key_addr_q, text_addr_q;
    logic [WIDTH_ENC_W-1:0]  text_width_q;
    logic [1:0]              issued, acked, win_mask, ack_mask;
    logic                    accept, issue_state, cur_tag, gate, win, ack_hit;
    logic                    timeout, retry_exhausted;

    assign accept       = cpu_req_valid && (state == S_IDLE) && (cpu_req_opcode != OP_RESERVED);
    assign issue_state  = (state == S_RD_KEY) || (state == S_RD_TEXT) || (state == S_EXEC) || (state == S_WB);
    assign cur_tag      = (state == S_WB) && issued[0];
    assign win          = req_valid && arb_won;
    assign ack_hit      = issue_state && ack && issued[ack_tag] && !acked[ack_tag];
    assign win_mask     = {win && cur_tag, win && !cur_tag};
    assign ack_mask     = {ack_hit && ack_tag, ack_hit && !ack_tag};
    assign req_source_id  = SRC_ID_W'(OUR_SRC_ID);
    assign cmpl_source_id = SRC_ID_W'(OUR_SRC_ID);

    always_comb begin
        cpu_req_ready = 1'b0;
        gate          = 1'b0;
        req_addr      = '0;
        req_width     = '0;
        req_opcode    = '0;
        req_accel_op  = 1'b0;
        req_tag       = 1'b0;
        req_is_mem    = 1'b0;
        cmpl_valid    = 1'b0;
        cmpl_addr     = '0;
        case (state)
            S_IDLE: cpu_req_ready = 1'b1;
            S_RD_KEY: begin
                gate       = mem_ready;
                req_addr   = key_addr_q;
                req_width  = KEY_WIDTH_ENC;
                req_opcode = NOC_MEM_READ;
                req_is_mem = 1'b1;
            end
            S_RD_TEXT: begin
                gate       = mem_ready;
                req_addr   = text_addr_q;
                req_width  = text_width_q;
                req_opcode = NOC_MEM_READ;
                req_is_mem = 1'b1;
            end
            S_EXEC: begin
                gate         = 1'b1;
                req_opcode   = NOC_EXEC;
                req_accel_op = (op_q == OP_AES_DEC);
            end
            S_WB: begin
                req_addr  = text_addr_q;
                req_width = text_width_q;
                // data packet follows the address packet as soon as the address wins
                if (!cur_tag) begin
                    gate       = mem_ready;
                    req_opcode = NOC_WRITE_ADDR;
                    req_is_mem = 1'b1;
                end else begin
                    gate       = 1'b1;
                    req_opcode = NOC_WRITE_DATA;
                    req_tag    = 1'b1;
                end
            end
            S_COMPLETE: begin
                cmpl_valid = 1'b1;
                cmpl_addr  = text_addr_q;
            end
            default: ;
        endcase
        req_valid = issue_state && !issued[cur_tag] && gate;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (accept) state_next = (cpu_req_opcode == OP_SHA) ? S_RD_TEXT : S_RD_KEY;
            S_RD_KEY:   if (acked[0]) state_next = S_RD_TEXT;
            S_RD_TEXT:  if (acked[0]) state_next = S_EXEC;
            S_EXEC:     if (acked[0]) state_next = S_WB;
            S_WB:       if (acked == 2'b11) state_next = S_COMPLETE;
            S_COMPLETE: if (serializer_arb_won) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
        if (retry_exhausted) state_next = S_COMPLETE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            op_q         <= '0;
            key_addr_q   <= '0;
            text_addr_q  <= '0;
            text_width_q <= '0;
            issued       <= '0;
            acked        <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q         <= cpu_req_opcode;
                key_addr_q   <= cpu_req_key_addr;
                text_addr_q  <= cpu_req_text_addr;
                text_width_q <= cpu_req_text_width;
            end
            if (state_next != state) begin
                issued <= '0;
                acked  <= '0;
            end else begin
                issued <= (timeout ? (issued & acked) : issued) | win_mask;
                acked  <= acked | ack_mask;
            end
        end
    end

`ifdef ACK_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RT_W = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [TO_W-1:0] to_cnt;
    logic [RT_W-1:0] retry_cnt;
    logic            pending, err_q;

    // the winning cycle counts as the first waiting cycle
    assign pending         = issue_state && ((|(issued & ~acked)) || win);
    assign timeout         = pending && !ack_hit && (to_cnt == '0);
    assign retry_exhausted = timeout && (int'(retry_cnt) == MAX_RETRY);
    assign cmpl_err        = err_q && (state == S_COMPLETE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt    <= TO_W'(TIMEOUT_CYC - 1);
            retry_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            if ((state_next != state) || ack_hit || timeout || !pending)
                to_cnt <= TO_W'(TIMEOUT_CYC - 1);
            else
                to_cnt <= to_cnt - TO_W'(1);
            if (state_next != state) retry_cnt <= '0;
            else if (timeout)        retry_cnt <= retry_cnt + RT_W'(1);
            if (retry_exhausted) err_q <= 1'b1;
            else if (accept)     err_q <= 1'b0;
        end
    end
`else
    assign timeout         = 1'b0;
    assign retry_exhausted = 1'b0;
    assign cmpl_err        = 1'b0;
`endif
endmodule

// File: tb/tb_ctrl_seq_fsm.sv
// Directed bench for ctrl_seq_fsm: acts as NoC/serializer responder and checks packet sequences.
module tb_ctrl_seq_fsm;
`ifdef ACK_TIMEOUT_EN
    localparam int TO = 8;
    localparam int MR = 2;
`else
    localparam int TO = 64;
    localparam int MR = 3;
`endif
    localparam logic [17:0] M_MEM  = 18'h3FFFE;
    localparam logic [17:0] M_EXEC = 18'h0001F;
    localparam logic [17:0] M_DATA = 18'h0001E;

    logic       clk = 1'b0;
    logic       rst_n, cpu_req_valid, cpu_req_ready;
    logic [1:0] cpu_req_opcode;
    logic [9:0] cpu_req_key_addr, cpu_req_text_addr;
    logic [2:0] cpu_req_text_width;
    logic       mem_ready, arb_won, ack, ack_tag, req_valid;
    logic [9:0] req_addr;
    logic [2:0] req_width;
    logic [1:0] req_opcode;
    logic       req_accel_op, req_tag, req_is_mem, cmpl_valid, cmpl_err, serializer_arb_won;
    logic [3:0] req_source_id, cmpl_source_id;
    logic [9:0] cmpl_addr;

    ctrl_seq_fsm #(.TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_opcode(cpu_req_opcode), .cpu_req_key_addr(cpu_req_key_addr),
        .cpu_req_text_addr(cpu_req_text_addr), .cpu_req_text_width(cpu_req_text_width),
        .mem_ready(mem_ready), .arb_won(arb_won), .ack(ack), .ack_tag(ack_tag),
        .req_valid(req_valid), .req_addr(req_addr), .req_width(req_width),
        .req_opcode(req_opcode), .req_accel_op(req_accel_op), .req_source_id(req_source_id),
        .req_tag(req_tag), .req_is_mem(req_is_mem),
        .cmpl_valid(cmpl_valid), .cmpl_addr(cmpl_addr), .cmpl_source_id(cmpl_source_id),
        .cmpl_err(cmpl_err), .serializer_arb_won(serializer_arb_won)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0;
    logic [17:0] pkt_q[$];
    int          pcyc_q[$];
    bit          cmpl_seen;
    logic [9:0]  cmpl_addr_s;
    logic        cmpl_err_s, ready_at_cmpl;
    int          cmpl_cyc, del0, del1;

    function automatic logic [17:0] pk(logic [9:0] a, logic [2:0] w, logic [1:0] o,
                                       logic m, logic t, logic x);
        return {a, w, o, m, t, x};
    endfunction

    function automatic logic [17:0] obs_pkt();
        return {req_addr, req_width, req_opcode, req_is_mem, req_tag, req_accel_op};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        cpu_req_valid = 0; ack = 0; ack_tag = 0; arb_won = 0; serializer_arb_won = 0; mem_ready = 1;
    endtask

    task automatic reset_noc();
        pkt_q.delete(); pcyc_q.delete();
        cmpl_seen = 0; cmpl_cyc = -1; cmpl_addr_s = '0; cmpl_err_s = 0; ready_at_cmpl = 0;
        del0 = -1; del1 = -1;
    endtask

    task automatic accept(input logic [1:0] opc, input logic [9:0] ka, input logic [9:0] ta,
                          input logic [2:0] w);
        cpu_req_opcode = opc; cpu_req_key_addr = ka; cpu_req_text_addr = ta;
        cpu_req_text_width = w; cpu_req_valid = 1;
    endtask

    // mode 0: ack each packet next cycle; 1: WB tag 0 acked two cycles after tag 1; 2: never ack
    task automatic noc_run(input int budget, input int mode, input int stop_opc);
        for (int c = 1; c <= budget; c++) begin
            cyc();
            cpu_req_valid = 0; ack = 0; ack_tag = 0; arb_won = 0; serializer_arb_won = 0;
            if (del0 > 0) del0--;
            if (del1 > 0) del1--;
            if (del0 == 0) begin ack = 1; ack_tag = 0; del0 = -1; end
            else if (del1 == 0) begin ack = 1; ack_tag = 1; del1 = -1; end
            #1;
            if (req_valid) begin
                arb_won = 1;
                pkt_q.push_back(obs_pkt());
                pcyc_q.push_back(c);
                if (mode != 2) begin
                    if (req_tag) del1 = 1;
                    else del0 = (mode == 1 && req_opcode == 2'd1) ? 4 : 1;
                end
                if (stop_opc >= 0 && int'(req_opcode) == stop_opc) break;
            end
            if (cmpl_valid) begin
                cmpl_seen = 1; cmpl_addr_s = cmpl_addr; cmpl_err_s = cmpl_err;
                cmpl_cyc = c; ready_at_cmpl = cpu_req_ready; serializer_arb_won = 1;
                break;
            end
        end
        cyc();
        clear_in();
    endtask

    task automatic test_reset();
        logic [39:0] got, exp;
        rst_n = 0; clear_in();
        cyc(); cyc();
        got = {cpu_req_ready, req_valid, cmpl_valid, cmpl_err, obs_pkt(), cmpl_addr,
               req_source_id, cmpl_source_id};
        exp = {1'b1, 39'b0};
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL reset_outputs: got %h expected %h", got, exp); end
        rst_n = 1;
        cyc();
        n_cmp++;
        if ({cpu_req_ready, req_valid} !== 2'b10) begin
            n_bad++; $display("FAIL reset_release: got %b expected 10", {cpu_req_ready, req_valid});
        end
    endtask

    task automatic test_aes_enc();
        logic [17:0] ex[5], mk[5];
        int ec[5];
        ex[0] = pk(10'h010, 3'd4, 2'd0, 1, 0, 0); mk[0] = M_MEM;  ec[0] = 1;
        ex[1] = pk(10'h200, 3'd2, 2'd0, 1, 0, 0); mk[1] = M_MEM;  ec[1] = 4;
        ex[2] = pk(10'h000, 3'd0, 2'd3, 0, 0, 0); mk[2] = M_EXEC; ec[2] = 7;
        ex[3] = pk(10'h200, 3'd2, 2'd1, 1, 0, 0); mk[3] = M_MEM;  ec[3] = 10;
        ex[4] = pk(10'h000, 3'd0, 2'd2, 0, 1, 0); mk[4] = M_DATA; ec[4] = 11;
        reset_noc();
        accept(2'd0, 10'h010, 10'h200, 3'd2);
        noc_run(60, 0, -1);
        n_cmp++;
        if (pkt_q.size() != 5) begin n_bad++; $display("FAIL aes_count: got %0d expected 5", pkt_q.size()); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (i >= pkt_q.size() || (pkt_q[i] & mk[i]) !== (ex[i] & mk[i]) || pcyc_q[i] != ec[i]) begin
                n_bad++;
                $display("FAIL aes_pkt%0d: got %h@%0d expected %h@%0d", i,
                         (i < pkt_q.size()) ? pkt_q[i] & mk[i] : 18'h0,
                         (i < pcyc_q.size()) ? pcyc_q[i] : -1, ex[i] & mk[i], ec[i]);
            end
        end
        n_cmp++;
        if (!cmpl_seen || cmpl_addr_s !== 10'h200 || cmpl_err_s !== 1'b0 || cmpl_cyc != 14 || ready_at_cmpl !== 1'b0) begin
            n_bad++;
            $display("FAIL aes_cmpl: got seen=%0d addr=%h err=%b cyc=%0d rdy=%b expected seen=1 addr=200 err=0 cyc=14 rdy=0",
                     cmpl_seen, cmpl_addr_s, cmpl_err_s, cmpl_cyc, ready_at_cmpl);
        end
        #1;
        n_cmp++;
        if ({cpu_req_ready, cmpl_valid} !== 2'b10) begin
            n_bad++; $display("FAIL aes_back_idle: got %b expected 10", {cpu_req_ready, cmpl_valid});
        end
    endtask

    task automatic test_aes_dec();
        logic [17:0] e0, e2;
        e0 = pk(10'h3F0, 3'd4, 2'd0, 1, 0, 0);
        e2 = pk(10'h000, 3'd0, 2'd3, 0, 0, 1);
        reset_noc();
        accept(2'd1, 10'h3F0, 10'h0AB, 3'd5);
        noc_run(60, 0, -1);
        n_cmp++;
        if (pkt_q.size() != 5 || (pkt_q[0] & M_MEM) !== (e0 & M_MEM) || (pkt_q[2] & M_EXEC) !== (e2 & M_EXEC)) begin
            n_bad++;
            $display("FAIL dec_pkts: got n=%0d p0=%h p2=%h expected n=5 p0=%h p2=%h", pkt_q.size(),
                     (pkt_q.size() > 0) ? pkt_q[0] & M_MEM : 18'h0,
                     (pkt_q.size() > 2) ? pkt_q[2] & M_EXEC : 18'h0, e0 & M_MEM, e2 & M_EXEC);
        end
        n_cmp++;
        if (!cmpl_seen || cmpl_addr_s !== 10'h0AB) begin
            n_bad++; $display("FAIL dec_cmpl: got seen=%0d addr=%h expected seen=1 addr=0ab", cmpl_seen, cmpl_addr_s);
        end
    endtask

    task automatic test_sha();
        logic [17:0] ex[4], mk[4];
        int ec[4];
        ex[0] = pk(10'h155, 3'd1, 2'd0, 1, 0, 0); mk[0] = M_MEM;  ec[0] = 1;
        ex[1] = pk(10'h000, 3'd0, 2'd3, 0, 0, 0); mk[1] = M_EXEC; ec[1] = 4;
        ex[2] = pk(10'h155, 3'd1, 2'd1, 1, 0, 0); mk[2] = M_MEM;  ec[2] = 7;
        ex[3] = pk(10'h000, 3'd0, 2'd2, 0, 1, 0); mk[3] = M_DATA; ec[3] = 8;
        reset_noc();
        accept(2'd2, 10'h111, 10'h155, 3'd1);
        noc_run(60, 0, -1);
        n_cmp++;
        if (pkt_q.size() != 4) begin n_bad++; $display("FAIL sha_count: got %0d expected 4", pkt_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= pkt_q.size() || (pkt_q[i] & mk[i]) !== (ex[i] & mk[i]) || pcyc_q[i] != ec[i]) begin
                n_bad++;
                $display("FAIL sha_pkt%0d: got %h@%0d expected %h@%0d", i,
                         (i < pkt_q.size()) ? pkt_q[i] & mk[i] : 18'h0,
                         (i < pcyc_q.size()) ? pcyc_q[i] : -1, ex[i] & mk[i], ec[i]);
            end
        end
        n_cmp++;
        if (!cmpl_seen || cmpl_cyc != 11 || cmpl_addr_s !== 10'h155) begin
            n_bad++; $display("FAIL sha_cmpl: got seen=%0d cyc=%0d addr=%h expected seen=1 cyc=11 addr=155",
                              cmpl_seen, cmpl_cyc, cmpl_addr_s);
        end
    endtask

    task automatic test_wb_reversed();
        reset_noc();
        accept(2'd0, 10'h020, 10'h300, 3'd3);
        noc_run(60, 1, -1);
        n_cmp++;
        if (pkt_q.size() != 5 || pcyc_q[3] != 10 || pcyc_q[4] != 11) begin
            n_bad++; $display("FAIL wbrev_pkts: got n=%0d expected n=5 with WB at cycles 10,11", pkt_q.size());
        end
        n_cmp++;
        if (!cmpl_seen || cmpl_cyc != 16 || cmpl_addr_s !== 10'h300) begin
            n_bad++; $display("FAIL wbrev_cmpl: got seen=%0d cyc=%0d addr=%h expected seen=1 cyc=16 addr=300",
                              cmpl_seen, cmpl_cyc, cmpl_addr_s);
        end
    endtask

    task automatic test_reserved();
        accept(2'd3, 10'h001, 10'h002, 3'd0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            n_cmp++;
            if ({cpu_req_ready, req_valid, cmpl_valid} !== 3'b100) begin
                n_bad++; $display("FAIL reserved_c%0d: got %b expected 100", c, {cpu_req_ready, req_valid, cmpl_valid});
            end
        end
        clear_in();
        cyc();
    endtask

    task automatic test_mem_stall();
        logic [17:0] e0;
        e0 = pk(10'h0F0, 3'd6, 2'd0, 1, 0, 0);
        reset_noc();
        accept(2'd2, 10'h000, 10'h0F0, 3'd6);
        mem_ready = 0;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            cpu_req_valid = 0;
            ack = (c == 2 || c == 3);
            ack_tag = (c == 2);
            #1;
            n_cmp++;
            if ({req_valid, cpu_req_ready} !== 2'b00) begin
                n_bad++; $display("FAIL stall_c%0d: got %b expected 00", c, {req_valid, cpu_req_ready});
            end
        end
        cyc();
        ack = 0; ack_tag = 0; mem_ready = 1;
        #1;
        n_cmp++;
        if (req_valid !== 1'b1 || (obs_pkt() & M_MEM) !== (e0 & M_MEM)) begin
            n_bad++; $display("FAIL stall_release: got v=%b %h expected v=1 %h", req_valid, obs_pkt() & M_MEM, e0 & M_MEM);
        end
        arb_won = 1; del0 = 1;
        noc_run(60, 0, -1);
        n_cmp++;
        if (!cmpl_seen || pkt_q.size() != 3 || cmpl_addr_s !== 10'h0F0) begin
            n_bad++; $display("FAIL stall_finish: got seen=%0d n=%0d addr=%h expected seen=1 n=3 addr=0f0",
                              cmpl_seen, pkt_q.size(), cmpl_addr_s);
        end
    endtask

    task automatic test_reset_mid();
        reset_noc();
        accept(2'd0, 10'h010, 10'h200, 3'd2);
        noc_run(60, 0, 3);
        n_cmp++;
        if (pkt_q.size() != 3 || cmpl_seen) begin
            n_bad++; $display("FAIL rstmid_reach_exec: got n=%0d seen=%0d expected n=3 seen=0", pkt_q.size(), cmpl_seen);
        end
        rst_n = 0;
        cyc();
        rst_n = 1; ack = 1; ack_tag = 0;
        #1;
        n_cmp++;
        if ({cpu_req_ready, req_valid, cmpl_valid} !== 3'b100) begin
            n_bad++; $display("FAIL rstmid_idle: got %b expected 100", {cpu_req_ready, req_valid, cmpl_valid});
        end
        for (int c = 0; c < 3; c++) begin
            cyc();
            ack = 0;
            #1;
            n_cmp++;
            if ({cpu_req_ready, req_valid, cmpl_valid} !== 3'b100) begin
                n_bad++; $display("FAIL rstmid_late_ack_c%0d: got %b expected 100", c, {cpu_req_ready, req_valid, cmpl_valid});
            end
        end
    endtask

`ifdef ACK_TIMEOUT_EN
    task automatic test_timeout();
        logic [17:0] e0;
        int ec[3];
        e0 = pk(10'h044, 3'd4, 2'd0, 1, 0, 0);
        ec[0] = 1; ec[1] = 9; ec[2] = 17;
        reset_noc();
        accept(2'd0, 10'h044, 10'h200, 3'd2);
        noc_run(80, 2, -1);
        n_cmp++;
        if (pkt_q.size() != 3) begin n_bad++; $display("FAIL to_count: got %0d expected 3", pkt_q.size()); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= pkt_q.size() || (pkt_q[i] & M_MEM) !== (e0 & M_MEM) || pcyc_q[i] != ec[i]) begin
                n_bad++; $display("FAIL to_pkt%0d: got %h@%0d expected %h@%0d", i,
                                  (i < pkt_q.size()) ? pkt_q[i] & M_MEM : 18'h0,
                                  (i < pcyc_q.size()) ? pcyc_q[i] : -1, e0 & M_MEM, ec[i]);
            end
        end
        n_cmp++;
        if (!cmpl_seen || cmpl_err_s !== 1'b1 || cmpl_cyc != 25) begin
            n_bad++; $display("FAIL to_cmpl: got seen=%0d err=%b cyc=%0d expected seen=1 err=1 cyc=25",
                              cmpl_seen, cmpl_err_s, cmpl_cyc);
        end
    endtask
`endif

    initial begin
        cpu_req_opcode = 0; cpu_req_key_addr = 0; cpu_req_text_addr = 0; cpu_req_text_width = 0;
        test_reset();
        test_aes_enc();
        test_aes_dec();
        test_sha();
        test_wb_reversed();
        test_reserved();
        test_mem_stall();
        test_reset_mid();
        test_sha();
`ifdef ACK_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ctrl_seq_fsm.md
Name: ctrl_seq_fsm

Overview:
- Parametrised successor to the per-request control FSM.
- Accepts one CPU crypto request and sequences its NoC transactions: key read, text read, accelerator execute, write-back address + data. It then posts a completion to the serializer.
- New behaviour:
  - Key read is skipped for keyless (SHA) opcodes.
  - Write-back address and data are issued back-to-back with per-tag ack tracking.
  - Outputs are fully width-parametrised.
  - Optional ack-timeout retry.

Parameters:
- ADDR_W, 10, address width
- CPU_OPCODE_W, 2, CPU opcode width
- OPCODE_W, 2, NoC opcode width
- WIDTH_ENC_W, 3, transfer-width encoding width
- SRC_ID_W, 4, source-ID width
- OUR_SRC_ID, 0, source ID stamped on every issued packet
- KEY_WIDTH_ENC, 3'd4, width encoding used for the key read
- TIMEOUT_CYC, 64, ack timeout in cycles (ACK_TIMEOUT_EN only)
- MAX_RETRY, 3, reissues allowed per phase (ACK_TIMEOUT_EN only)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cpu_req_valid  in  1  request-queue entry valid
- cpu_req_ready  out  1  FSM can accept a request
- cpu_req_opcode  in  CPU_OPCODE_W  0 = AES_ENC, 1 = AES_DEC, 2 = SHA, 3 = reserved
- cpu_req_key_addr  in  ADDR_W  key address
- cpu_req_text_addr  in  ADDR_W  text / result address
- cpu_req_text_width  in  WIDTH_ENC_W  text width encoding
- mem_ready  in  1  memory resource free
- arb_won  in  1  NoC arbiter accepted the current req
- ack  in  1  packet acknowledged
- ack_tag  in  1  0 = first/only packet of phase, 1 = write-back data packet
- req_valid  out  1  request to NoC arbiter
- req_addr  out  ADDR_W  packet address
- req_width  out  WIDTH_ENC_W  packet width encoding
- req_opcode  out  OPCODE_W  0 = MEM_READ, 1 = MEM_WRITE_ADDR, 2 = ACCEL_WRITE_DATA, 3 = ACCEL_EXEC
- req_accel_op  out  1  for ACCEL_EXEC: 0 = encrypt/hash, 1 = decrypt
- req_source_id  out  SRC_ID_W  always OUR_SRC_ID
- req_tag  out  1  tag expected back on ack_tag
- req_is_mem  out  1  1 = memory target, 0 = accelerator target
- cmpl_valid  out  1  completion to serializer
- cmpl_addr  out  ADDR_W  latched text address
- cmpl_source_id  out  SRC_ID_W  OUR_SRC_ID
- cmpl_err  out  1  request aborted (ACK_TIMEOUT_EN only, else 0)
- serializer_arb_won  in  1  completion accepted

Behaviour:
- Reset (synchronous, rst_n low at posedge):
  - State goes to IDLE; all latches, masks and counters clear.
  - Every output is 0 except cpu_req_ready = 1 and req_source_id / cmpl_source_id = OUR_SRC_ID.
  - Reset mid-operation abandons the request with no completion. Late acks are ignored.
- States: IDLE, RD_KEY, RD_TEXT, EXEC, WB, COMPLETE.
- IDLE:
  - cpu_req_ready = 1 only in IDLE.
  - A request is accepted when cpu_req_valid & cpu_req_ready at a posedge; opcode, addresses and width are latched.
  - Opcode 3 is reserved: ignored and not accepted (cpu_req_ready stays 1).
  - Next state is RD_KEY for AES, RD_TEXT for SHA.
- Issue rule (all issue states):
  - req_valid is combinational: issue state & !issued(tag) & gate.
  - Gate is mem_ready for RD_KEY, RD_TEXT and WB tag 0; it is 1 for EXEC and WB tag 1.
  - Once req_valid is high, req fields are stable until arb_won. If arb_won is sampled with req_valid, issued(tag) is set.
  - arb_won without req_valid is ignored.
- Ack rule:
  - ack with ack_tag matching an issued, unacked tag sets acked(tag). Any other ack is ignored, including acks in IDLE/COMPLETE.
  - A single-tag phase advances the cycle after acked(0) is set.
- Per-phase packets:
  - RD_KEY: addr = key_addr, width = KEY_WIDTH_ENC, MEM_READ, is_mem = 1, tag 0.
  - RD_TEXT: addr = text_addr, width = text_width, MEM_READ, is_mem = 1, tag 0.
  - EXEC: ACCEL_EXEC, req_accel_op = (opcode == AES_DEC), is_mem = 0, tag 0.
  - WB: tag 0 is MEM_WRITE_ADDR to text_addr, is_mem = 1. Tag 1 is ACCEL_WRITE_DATA, is_mem = 0, offered the cycle after tag 0 wins without waiting for ack 0. WB exits only when acked = 2'b11; acks may arrive in either order.
- Latency: accept at cycle 0 gives req_valid in cycle 1 if mem_ready = 1.
- COMPLETE:
  - cmpl_valid = 1 and cmpl_addr = text_addr, held until serializer_arb_won. Then IDLE with cpu_req_ready = 1 next cycle.
  - No completion-to-accept bypass.
- Issued/acked masks clear on every state transition.

Optional Feature:
- ACK_TIMEOUT_EN.
- Defined:
  - A counter starts when a phase has an issued-but-unacked tag. It resets on any matching ack or state change.
  - At TIMEOUT_CYC the unacked tags' issued bits clear (reissue) and the retry count increments.
  - Once MAX_RETRY reissues in one phase have been exhausted, the next timeout jumps to COMPLETE with cmpl_err = 1.
- Undefined: no counters; FSM waits indefinitely; cmpl_err tied 0.

Test Plan:
- AES_ENC: key_addr = 0x010, text_addr = 0x200, width = 3'd2, mem_ready = 1, arb_won immediate, ack next cycle.
  - Expect packets READ@0x010 w4, READ@0x200 w2, EXEC op0, WRITE_ADDR@0x200 then WRITE_DATA in consecutive cycles.
  - Then cmpl_valid, cmpl_addr = 0x200.
- SHA: no RD_KEY packet, first packet READ@text_addr, cycle 1 after accept.
- WB acks reversed (tag 1 then tag 0 two cycles later): stays in WB until the second ack, then COMPLETE.
- mem_ready = 0 for 5 cycles in RD_TEXT: req_valid stays 0 throughout, then rises the cycle after mem_ready = 1. Stray ack / ack_tag = 1 in RD_TEXT is ignored.
- rst_n low during EXEC: next cycle IDLE, req_valid = 0, cpu_req_ready = 1. A late ack is ignored.
- ACK_TIMEOUT_EN, TIMEOUT_CYC = 8, MAX_RETRY = 2, no acks in RD_KEY: three READ@key_addr packets 8 cycles apart, then cmpl_valid with cmpl_err = 1.
